// File: rtl/servo_ramp_ctrl_if.sv
// ---------------------------------------------------------------------------
// servo_ramp_ctrl_if
//   Command port of the servo ramp controller: a valid/ready write of one
//   target position to one channel, plus a drop indication.
//   Signals:
//     cmd_valid  master->slave  command present
//     cmd_sel    master->slave  target channel index ($clog2(NCH)+1 bits)
//     cmd_pos    master->slave  requested pulse width in ticks (unsigned)
//     cmd_ready  slave->master  slave can accept a command this clock
//     cmd_err    slave->master  1-clk pulse, command dropped (bad channel)
// ---------------------------------------------------------------------------
interface servo_ramp_ctrl_if #(
    parameter int NCH = 4,
    parameter int W   = 16
);
    localparam int SW = $clog2(NCH) + 1;

    logic          cmd_valid;
    logic [SW-1:0] cmd_sel;
    logic [W-1:0]  cmd_pos;
    logic          cmd_ready;
    logic          cmd_err;

    modport master (
        output cmd_valid, cmd_sel, cmd_pos,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_pos,
        output cmd_ready, cmd_err
    );
endinterface

// File: rtl/servo_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// servo_ramp_ctrl
//   Multi-channel RC-servo pulse generator. Each channel holds a clamped
//   target width; the live width slews toward it by at most STEP ticks per
//   frame. All channels share one prescaler/frame timebase.
//   Ports:
//     clk       system clock
//     nrst      asynchronous active-low reset
//     en        1 = pulses active and ramp running; 0 = pulses low, ramp frozen
//     cmd       command port (slave modport of servo_ramp_ctrl_if)
//     pulse     per-channel servo PWM lines (registered)
//     busy      per-channel live width != target (registered)
//     frame_tc  1-clk pulse following the frame wrap
// ---------------------------------------------------------------------------
module servo_ramp_ctrl #(
    parameter int NCH      = 4,
    parameter int W        = 16,
    parameter int TICK_DIV = 269,
    parameter int PERIOD   = 1999,
    parameter int POS_MIN  = 60,
    parameter int POS_MAX  = 230,
    parameter int POS_RST  = 100,
    parameter int STEP     = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    servo_ramp_ctrl_if.slave  cmd,
    output logic [NCH-1:0]    pulse,
    output logic [NCH-1:0]    busy,
    output logic              frame_tc
);
    localparam int SW = $clog2(NCH) + 1;

    localparam logic [W-1:0]  TICK_T   = W'(TICK_DIV);
    localparam logic [W-1:0]  PERIOD_T = W'(PERIOD);
    localparam logic [W-1:0]  MIN_T    = W'(POS_MIN);
    localparam logic [W-1:0]  MAX_T    = W'(POS_MAX);
    localparam logic [W-1:0]  RST_T    = W'(POS_RST);
    localparam logic [W:0]    STEP_X   = (W+1)'(STEP);
    localparam logic [SW-1:0] NCH_S    = SW'(NCH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    function automatic logic [W-1:0] clamp_pos(input logic [W-1:0] p);
        if (p < MIN_T)      clamp_pos = MIN_T;
        else if (p > MAX_T) clamp_pos = MAX_T;
        else                clamp_pos = p;
    endfunction

    // One ramp step toward tgt; the step is limited to the remaining
    // distance so the live width never overshoots.
    function automatic logic [W-1:0] ramp_step(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt);
        logic [W:0] c, t, d;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        d = '0;
        ramp_step = cur;
        if (c < t) begin
            d = t - c;
            if (d > STEP_X) d = STEP_X;
            ramp_step = W'(c + d);
        end else if (c > t) begin
            d = c - t;
            if (d > STEP_X) d = STEP_X;
            ramp_step = W'(c - d);
        end
    endfunction

    logic [W-1:0]   presc_q, presc_d;
    logic [W-1:0]   frame_q, frame_d;
    logic           frame_tc_q;
    logic           tick, wrap;
    logic [0:0]     state_q, state_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic [W-1:0]   pos_q, pos_d;
    logic           write_ok;
    logic [W-1:0]   cur_q [NCH];
    logic [W-1:0]   cur_d [NCH];
    logic [W-1:0]   tgt_q [NCH];
    logic [W-1:0]   tgt_d [NCH];
    logic [NCH-1:0] pulse_q, pulse_d;
    logic [NCH-1:0] busy_q, busy_d;

    // Timebase: prescaler produces tick, frame counter wraps at PERIOD.
    always_comb begin
        tick    = (presc_q == TICK_T);
        wrap    = tick && (frame_q == PERIOD_T);
        presc_d = tick ? '0 : presc_q + W'(1);
        frame_d = frame_q;
        if (wrap)      frame_d = '0;
        else if (tick) frame_d = frame_q + W'(1);
    end

    // Command FSM: IDLE latches a command, WRITE commits it for one clock.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pos_d   = pos_q;
        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    sel_d   = cmd.cmd_sel;
                    pos_d   = cmd.cmd_pos;
                    state_d = S_WRITE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign write_ok      = (state_q == S_WRITE) && (sel_q < NCH_S);
    assign cmd.cmd_err   = (state_q == S_WRITE) && !(sel_q < NCH_S);
    assign cmd.cmd_ready = (state_q == S_IDLE);

    // Ramp reads tgt_q, so a write landing on the wrap clock only takes
    // effect at the following wrap. Pulse compares against cur_q, which only
    // moves at the wrap, so a frame's width is fixed once it starts.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            tgt_d[i]   = (write_ok && (sel_q == SW'(i))) ? clamp_pos(pos_q) : tgt_q[i];
            cur_d[i]   = (wrap && en) ? ramp_step(cur_q[i], tgt_q[i]) : cur_q[i];
            pulse_d[i] = en && (frame_q < cur_q[i]);
            busy_d[i]  = (cur_q[i] != tgt_q[i]);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc_q    <= '0;
            frame_q    <= '0;
            frame_tc_q <= 1'b0;
            state_q    <= S_IDLE;
            pulse_q    <= '0;
            busy_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                cur_q[i] <= RST_T;
                tgt_q[i] <= RST_T;
            end
        end else begin
            presc_q    <= presc_d;
            frame_q    <= frame_d;
            frame_tc_q <= wrap;
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            for (int i = 0; i < NCH; i++) begin
                cur_q[i] <= cur_d[i];
                tgt_q[i] <= tgt_d[i];
            end
        end
    end

    // Command holding registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        sel_q <= sel_d;
        pos_q <= pos_d;
    end

    assign pulse    = pulse_q;
    assign busy     = busy_q;
    assign frame_tc = frame_tc_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_servo_ramp_ctrl
//   Directed bench for servo_ramp_ctrl with a fast timebase
//   (TICK_DIV=1 -> 2 clk per tick, PERIOD=299 -> 600 clk per frame).
//   Pulse widths are counted in clocks over one frame, so a width of N ticks
//   reads as 2*N high samples.
// ---------------------------------------------------------------------------
module tb_servo_ramp_ctrl;
    localparam int NCH   = 4;
    localparam int W     = 16;
    localparam int SW    = $clog2(NCH) + 1;
    localparam int FRAME = 600;

    logic           clk  = 1'b0;
    logic           nrst = 1'b0;
    logic           en   = 1'b1;
    logic [NCH-1:0] pulse;
    logic [NCH-1:0] busy;
    logic           frame_tc;

    servo_ramp_ctrl_if #(.NCH(NCH), .W(W)) cmd_if ();

    servo_ramp_ctrl #(
        .NCH(NCH), .W(W), .TICK_DIV(1), .PERIOD(299),
        .POS_MIN(60), .POS_MAX(230), .POS_RST(100), .STEP(2)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .cmd      (cmd_if),
        .pulse    (pulse),
        .busy     (busy),
        .frame_tc (frame_tc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int w [NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected widths are given in ticks.
    task automatic chk_w(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [NCH];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < NCH; i++)
            chk($sformatf("%s_ch%0d", tag, i), 32'(w[i]), 32'(2 * e[i]));
    endtask

    // Entered on the negedge where frame_tc is seen; leaves on the next one.
    // Optionally issues one command at sample index cmd_at (0 = none).
    task automatic measure(input int cmd_at, input int sel, input int pos);
        for (int i = 0; i < NCH; i++) w[i] = 0;
        for (int s = 1; s <= FRAME; s++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) if (pulse[i]) w[i]++;
            if (s == 1) chk("frame_tc_one_clk", 32'(frame_tc), 32'(0));
            if (s == cmd_at) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_sel   = SW'(sel);
                cmd_if.cmd_pos   = W'(pos);
            end else if (s == cmd_at + 1) begin
                cmd_if.cmd_valid = 1'b0;
            end
        end
        chk("frame_tc_period", 32'(frame_tc), 32'(1));
    endtask

    task automatic wait_tc(input int max_clk);
        bit found = 1'b0;
        for (int c = 0; c < max_clk && !found; c++) begin
            @(negedge clk);
            if (frame_tc) found = 1'b1;
        end
        chk("wait_frame_tc", 32'(found), 32'(1));
    endtask

    // Drives at the current negedge; returns two negedges later, ready again.
    task automatic send_cmd(input int sel, input int pos, input int exp_err);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_sel   = SW'(sel);
        cmd_if.cmd_pos   = W'(pos);
        chk("cmd_ready_idle", 32'(cmd_if.cmd_ready), 32'(1));
        @(negedge clk);
        chk("cmd_ready_write", 32'(cmd_if.cmd_ready), 32'(0));
        chk("cmd_err_write", 32'(cmd_if.cmd_err), 32'(exp_err));
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        chk("cmd_ready_back", 32'(cmd_if.cmd_ready), 32'(1));
        chk("cmd_err_clear", 32'(cmd_if.cmd_err), 32'(0));
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_sel   = '0;
        cmd_if.cmd_pos   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pulse", 32'(pulse), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_frame_tc", 32'(frame_tc), 32'(0));
        chk("rst_ready", 32'(cmd_if.cmd_ready), 32'(1));
        chk("rst_err", 32'(cmd_if.cmd_err), 32'(0));
        nrst = 1'b1;

        // T1: all channels at reset width
        wait_tc(2 * FRAME + 100);
        measure(0, 0, 0);
        chk_w("T1", 100, 100, 100, 100);
        chk("T1_busy", 32'(busy), 32'(0));

        // T2: ch1 -> 160 ramps 102..160 over 30 frames
        send_cmd(1, 160, 0);
        @(negedge clk);
        chk("T2_busy_set", 32'(busy), 32'(4'b0010));
        wait_tc(FRAME + 50);
        for (int j = 1; j <= 30; j++) begin
            measure(0, 0, 0);
            chk($sformatf("T2_f%0d_ch1", j), 32'(w[1]), 32'(2 * (100 + 2 * j)));
        end
        chk_w("T2_end", 100, 160, 100, 100);
        @(negedge clk);
        chk("T2_busy_clear", 32'(busy), 32'(0));

        // T3: clamp low, clamp high, odd final step without overshoot
        send_cmd(0, 10, 0);
        send_cmd(2, 500, 0);
        send_cmd(3, 105, 0);
        wait_tc(FRAME + 50);
        for (int j = 1; j <= 66; j++) begin
            measure(0, 0, 0);
            chk($sformatf("T3_f%0d_ch0", j), 32'(w[0]), 32'(2 * ((100 - 2 * j) < 60 ? 60 : (100 - 2 * j))));
            chk($sformatf("T3_f%0d_ch1", j), 32'(w[1]), 32'(320));
            chk($sformatf("T3_f%0d_ch2", j), 32'(w[2]), 32'(2 * ((100 + 2 * j) > 230 ? 230 : (100 + 2 * j))));
            chk($sformatf("T3_f%0d_ch3", j), 32'(w[3]), 32'(2 * ((100 + 2 * j) > 105 ? 105 : (100 + 2 * j))));
        end
        @(negedge clk);
        chk("T3_busy_clear", 32'(busy), 32'(0));

        // T4: out-of-range channel indices are dropped
        send_cmd(5, 150, 1);
        send_cmd(4, 150, 1);
        @(negedge clk);
        chk("T4_busy", 32'(busy), 32'(0));
        wait_tc(FRAME + 50);
        measure(0, 0, 0);
        chk_w("T4", 60, 160, 230, 105);

        // T5: mid-frame write, then write on the wrap clock
        measure(300, 1, 150);
        chk("T5_midframe_cur", 32'(w[1]), 32'(320));
        measure(598, 1, 200);
        chk("T5_first_step", 32'(w[1]), 32'(316));
        measure(0, 0, 0);
        chk("T5_wrap_old_tgt", 32'(w[1]), 32'(312));

        // en=0: pulses low, ramp frozen
        en = 1'b0;
        measure(0, 0, 0);
        chk_w("T6_en_off", 0, 0, 0, 0);
        en = 1'b1;
        measure(0, 0, 0);
        chk("T6_frozen", 32'(w[1]), 32'(316));
        measure(0, 0, 0);
        chk("T6_resume", 32'(w[1]), 32'(320));

        // T6: asynchronous reset mid-pulse, mid-ramp
        repeat (50) @(negedge clk);
        chk("T6_pre_pulse", 32'(pulse[1]), 32'(1));
        chk("T6_pre_busy", 32'(busy), 32'(4'b0010));
        nrst = 1'b0;
        #1;
        chk("T6_rst_pulse", 32'(pulse), 32'(0));
        chk("T6_rst_busy", 32'(busy), 32'(0));
        chk("T6_rst_ready", 32'(cmd_if.cmd_ready), 32'(1));
        chk("T6_rst_frame_tc", 32'(frame_tc), 32'(0));
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        wait_tc(FRAME + 100);
        measure(0, 0, 0);
        chk_w("T6_after_rst", 100, 100, 100, 100);
        chk("T6_after_busy", 32'(busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
